// File: rtl/global_defs.sv
// Shared types for the DRAM controller model: parser output, opcodes and
// the request-queue entry layout.
package global_defs;

    localparam int ADDRESS_WIDTH = 32;
    localparam int QUEUE_DEPTH   = 16;

    typedef logic [31:0] int_t;

    localparam int_t TIME_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } parsed_op_t;

    typedef struct packed {
        parsed_op_t               opcode;
        logic [ADDRESS_WIDTH-1:0] address;
        int_t                     time_cpu;
        logic                     op_ready_s;
    } parser_out_struct_t;

    typedef struct packed {
        parsed_op_t               opcode;
        logic [ADDRESS_WIDTH-1:0] address;
        int_t                     time_cpu;
        int_t                     enq_time;
    } queue_entry_t;

endpackage

// File: rtl/request_queue_storage.sv
// Circular entry buffer: DEPTH registers addressed by head/tail pointers that
// wrap naturally because DEPTH is a power of two.
module queue_storage
    import global_defs::queue_entry_t;
#(
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  queue_entry_t wr_entry,
    output queue_entry_t rd_entry
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    queue_entry_t     mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + 1'b1;
            if (pop)  head_ptr <= head_ptr + 1'b1;
        end
    end

    // NOTE: the array is deliberately not reset; stale slots are unreachable
    // because the top gates the head with its occupancy count.
    always_ff @(posedge clk) begin
        if (push) mem[tail_ptr] <= wr_entry;
    end

    assign rd_entry = mem[head_ptr];

endmodule

// File: rtl/request_queue.sv
// In-order request queue between the trace parser and the scheduler; owns the
// simulated CPU clock and skips it forward when there is nothing to do.
module request_queue
    import global_defs::int_t;
    import global_defs::parser_out_struct_t;
    import global_defs::queue_entry_t;
    import global_defs::NOP;
    import global_defs::TIME_MAX;
#(
    parameter int QUEUE_DEPTH   = global_defs::QUEUE_DEPTH,
    parameter int ADDRESS_WIDTH = global_defs::ADDRESS_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  parser_out_struct_t             in_req,
    input  logic                           pop,
    output int_t                           queue_time,
    output logic                           queue_full,
    output logic                           queue_empty,
    output logic                           pending_request,
    output logic [$clog2(QUEUE_DEPTH):0]   occupancy,
    output logic                           head_valid,
    output queue_entry_t                   head,
    output int_t                           head_age
);

    localparam int OCC_W = $clog2(QUEUE_DEPTH) + 1;

    if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("QUEUE_DEPTH must be a power of two and at least 2");
    end
    if (ADDRESS_WIDTH != global_defs::ADDRESS_WIDTH) begin : g_bad_addr
        $error("ADDRESS_WIDTH must match the width baked into queue_entry_t");
    end

    logic [OCC_W-1:0] occ_q, occ_d;
    int_t             time_q, time_d;
    logic             pend_q;
    logic             candidate, accept, do_pop, time_skip;
    queue_entry_t     wr_entry, rd_entry;

    // Flags come from registered occupancy only, so a same-cycle pop never
    // opens a slot for a push into a full queue.
    assign queue_full  = (occ_q == OCC_W'(QUEUE_DEPTH));
    assign queue_empty = (occ_q == '0);
    assign head_valid  = !queue_empty;

    assign candidate = in_req.op_ready_s && (in_req.opcode != NOP);
    assign accept    = candidate && !queue_full && (in_req.time_cpu <= time_q);
    assign do_pop    = pop && head_valid;
    assign time_skip = queue_empty && candidate && (in_req.time_cpu > time_q);

    // NOTE: combinational next-state uses blocking assignments with defaults
    // first, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        time_d = time_q;
        if (time_skip) begin
            time_d = in_req.time_cpu;
        end else if (time_q != TIME_MAX) begin
            time_d = time_q + 32'd1;
        end

        occ_d = occ_q;
        case ({accept, do_pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q  <= '0;
            time_q <= '0;
            pend_q <= 1'b0;
        end else begin
            occ_q  <= occ_d;
            time_q <= time_d;
            pend_q <= candidate && !accept;
        end
    end

    always_comb begin
        wr_entry          = '0;
        wr_entry.opcode   = in_req.opcode;
        wr_entry.address  = in_req.address;
        wr_entry.time_cpu = in_req.time_cpu;
        wr_entry.enq_time = time_q;
    end

    queue_storage #(
        .DEPTH(QUEUE_DEPTH)
    ) u_storage (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (accept),
        .pop      (do_pop),
        .wr_entry (wr_entry),
        .rd_entry (rd_entry)
    );

    assign head            = head_valid ? rd_entry : '0;
    assign head_age        = head_valid ? (time_q - rd_entry.enq_time) : '0;
    assign queue_time      = time_q;
    assign pending_request = pend_q;
    assign occupancy       = occ_q;

endmodule

// File: tb/tb_request_queue.sv
// Directed bench for request_queue: a per-cycle vector table plus hand-written
// sequences for full, wrap-around, saturation and mid-run reset.
module tb_request_queue;
    import global_defs::*;

    localparam int DEPTH = 16;

    typedef struct {
        logic       rdy;
        parsed_op_t op;
        int_t       addr;
        int_t       tcpu;
        logic       pop;
        int         occ;
        logic       pend;
        int_t       qt;
        logic       hv;
        int_t       h_addr;
        int_t       h_enq;
        int_t       age;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    parser_out_struct_t in_req;
    logic               pop;
    int_t               queue_time;
    logic               queue_full;
    logic               queue_empty;
    logic               pending_request;
    logic [4:0]         occupancy;
    logic               head_valid;
    queue_entry_t       head;
    int_t               head_age;

    int n_vec = 0;
    int n_err = 0;

    vec_t tbl [18];
    int_t model [$];

    request_queue #(.QUEUE_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_req          (in_req),
        .pop             (pop),
        .queue_time      (queue_time),
        .queue_full      (queue_full),
        .queue_empty     (queue_empty),
        .pending_request (pending_request),
        .occupancy       (occupancy),
        .head_valid      (head_valid),
        .head            (head),
        .head_age        (head_age)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input parsed_op_t op, input int_t addr,
                         input int_t tcpu, input logic p);
        in_req.op_ready_s = rdy;
        in_req.opcode     = op;
        in_req.address    = addr;
        in_req.time_cpu   = tcpu;
        pop               = p;
    endtask

    task automatic do_reset(input string tag);
        drive(1'b0, NOP, 0, 0, 1'b0);
        rst_n = 1'b0;
        tick();
        check({tag, "_occ"},   64'(occupancy), 0);
        check({tag, "_qtime"}, 64'(queue_time), 0);
        check({tag, "_pend"},  64'(pending_request), 0);
        check({tag, "_empty"}, 64'(queue_empty), 1);
        check({tag, "_full"},  64'(queue_full), 0);
        check({tag, "_hv"},    64'(head_valid), 0);
        check({tag, "_head0"}, 64'(head == '0), 1);
        check({tag, "_age"},   64'(head_age), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        //         rdy   op     addr   tcpu pop  occ pend qt   hv  h_addr h_enq age
        tbl[0]  = '{1'b0, NOP,   0,     0,   1'b0, 0, 1'b0, 1,   1'b0, 0,     0,   0};
        tbl[1]  = '{1'b1, READ,  'hA1,  100, 1'b0, 0, 1'b1, 100, 1'b0, 0,     0,   0};
        tbl[2]  = '{1'b1, READ,  'hA1,  100, 1'b0, 1, 1'b0, 101, 1'b1, 'hA1,  100, 1};
        tbl[3]  = '{1'b1, NOP,   'hEE,  0,   1'b0, 1, 1'b0, 102, 1'b1, 'hA1,  100, 2};
        tbl[4]  = '{1'b0, NOP,   0,     0,   1'b1, 0, 1'b0, 103, 1'b0, 0,     0,   0};
        tbl[5]  = '{1'b0, NOP,   0,     0,   1'b1, 0, 1'b0, 104, 1'b0, 0,     0,   0};
        tbl[6]  = '{1'b1, READ,  'h10,  5,   1'b0, 1, 1'b0, 105, 1'b1, 'h10,  104, 1};
        tbl[7]  = '{1'b1, WRITE, 'h20,  5,   1'b0, 2, 1'b0, 106, 1'b1, 'h10,  104, 2};
        tbl[8]  = '{1'b1, READ,  'h30,  6,   1'b0, 3, 1'b0, 107, 1'b1, 'h10,  104, 3};
        tbl[9]  = '{1'b0, NOP,   0,     0,   1'b1, 2, 1'b0, 108, 1'b1, 'h20,  105, 3};
        tbl[10] = '{1'b0, NOP,   0,     0,   1'b1, 1, 1'b0, 109, 1'b1, 'h30,  106, 3};
        tbl[11] = '{1'b1, READ,  'h40,  7,   1'b1, 1, 1'b0, 110, 1'b1, 'h40,  109, 1};
        tbl[12] = '{1'b0, NOP,   0,     0,   1'b1, 0, 1'b0, 111, 1'b0, 0,     0,   0};
        tbl[13] = '{1'b1, READ,  'h50,  111, 1'b0, 1, 1'b0, 112, 1'b1, 'h50,  111, 1};
        tbl[14] = '{1'b1, READ,  'h60,  200, 1'b0, 1, 1'b1, 113, 1'b1, 'h50,  111, 2};
        tbl[15] = '{1'b1, READ,  'h60,  200, 1'b1, 0, 1'b1, 114, 1'b0, 0,     0,   0};
        tbl[16] = '{1'b1, READ,  'h60,  200, 1'b0, 0, 1'b1, 200, 1'b0, 0,     0,   0};
        tbl[17] = '{1'b1, READ,  'h60,  200, 1'b0, 1, 1'b0, 201, 1'b1, 'h60,  200, 1};

        do_reset("rst0");

        // Vector table: time skip, FIFO order, push+pop, NOP, pop on empty.
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].rdy, tbl[i].op, tbl[i].addr, tbl[i].tcpu, tbl[i].pop);
            tick();
            check($sformatf("v%0d_occ", i),   64'(occupancy), 64'(tbl[i].occ));
            check($sformatf("v%0d_pend", i),  64'(pending_request), 64'(tbl[i].pend));
            check($sformatf("v%0d_qtime", i), 64'(queue_time), 64'(tbl[i].qt));
            check($sformatf("v%0d_hv", i),    64'(head_valid), 64'(tbl[i].hv));
            check($sformatf("v%0d_haddr", i), 64'(head.address), 64'(tbl[i].h_addr));
            check($sformatf("v%0d_henq", i),  64'(head.enq_time), 64'(tbl[i].h_enq));
            check($sformatf("v%0d_age", i),   64'(head_age), 64'(tbl[i].age));
        end

        // Full queue: 17th request is held off until a pop frees a slot.
        do_reset("rst_full");
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, READ, int_t'(i), 0, 1'b0);
            tick();
        end
        check("full_occ",  64'(occupancy), 16);
        check("full_flag", 64'(queue_full), 1);
        drive(1'b1, READ, 16, 0, 1'b0);
        tick();
        check("full_17_pend", 64'(pending_request), 1);
        check("full_17_occ",  64'(occupancy), 16);
        drive(1'b1, READ, 16, 0, 1'b1);
        tick();
        check("full_pop_occ",  64'(occupancy), 15);
        check("full_pop_flag", 64'(queue_full), 0);
        check("full_pop_pend", 64'(pending_request), 1);
        check("full_pop_head", 64'(head.address), 1);
        drive(1'b1, READ, 16, 0, 1'b0);
        tick();
        check("full_acc_occ",  64'(occupancy), 16);
        check("full_acc_pend", 64'(pending_request), 0);
        check("full_acc_flag", 64'(queue_full), 1);
        for (int i = 1; i <= DEPTH; i++) begin
            check($sformatf("drain%0d_addr", i), 64'(head.address), 64'(i));
            drive(1'b0, NOP, 0, 0, 1'b1);
            tick();
        end
        check("drain_empty", 64'(queue_empty), 1);

        // Wrap-around: alternating push/pop against a reference queue.
        do_reset("rst_wrap");
        for (int i = 0; i < 40; i++) begin
            int_t a;
            parsed_op_t op;
            a  = $urandom;
            op = (i % 2 == 0) ? READ : WRITE;
            model.push_back(a);
            drive(1'b1, op, a, 0, 1'b0);
            tick();
            check($sformatf("wrap%0d_occ1", i), 64'(occupancy), 1);
            check($sformatf("wrap%0d_addr", i), 64'(head.address), 64'(model[0]));
            check($sformatf("wrap%0d_op", i),   64'(head.opcode), 64'(op));
            void'(model.pop_front());
            drive(1'b0, NOP, 0, 0, 1'b1);
            tick();
            check($sformatf("wrap%0d_occ0", i), 64'(occupancy), 0);
        end

        // Saturation: skip straight to the top of the time range.
        do_reset("rst_sat");
        drive(1'b1, WRITE, 'h77, 32'hFFFF_FFFF, 1'b0);
        tick();
        check("sat_skip_qt",   64'(queue_time), 64'hFFFF_FFFF);
        check("sat_skip_pend", 64'(pending_request), 1);
        tick();
        check("sat_acc_occ", 64'(occupancy), 1);
        check("sat_acc_qt",  64'(queue_time), 64'hFFFF_FFFF);
        drive(1'b0, NOP, 0, 0, 1'b0);
        tick();
        check("sat_hold_qt", 64'(queue_time), 64'hFFFF_FFFF);
        check("sat_age",     64'(head_age), 0);

        // Reset mid-run with seven entries, then a fresh time skip.
        do_reset("rst_mid_pre");
        drive(1'b1, READ, 'h500, 500, 1'b0);
        tick();
        check("mid_skip_qt", 64'(queue_time), 500);
        for (int i = 0; i < 7; i++) tick();
        check("mid_occ7", 64'(occupancy), 7);
        check("mid_qt",   64'(queue_time), 507);
        do_reset("rst_mid");
        drive(1'b1, READ, 'h3, 3, 1'b0);
        tick();
        check("post_skip_qt",   64'(queue_time), 3);
        check("post_skip_pend", 64'(pending_request), 1);
        check("post_skip_occ",  64'(occupancy), 0);
        tick();
        check("post_acc_occ",  64'(occupancy), 1);
        check("post_acc_hv",   64'(head_valid), 1);
        check("post_acc_tcpu", 64'(head.time_cpu), 3);
        check("post_acc_enq",  64'(head.enq_time), 3);
        check("post_acc_pend", 64'(pending_request), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
